// File: rtl/mips32_data_mem_responder.sv
// -----------------------------------------------------------------------------
// mips32_data_mem_responder
//   Word-addressed data-memory responder for the MIPS32 pipelined core.
//   Accepts one load/store request at a time, waits WAIT_CYCLES extra cycles to
//   model slow memory, performs the access and holds the response until the
//   initiator accepts it. The storage array is named MEM so it can be preloaded
//   and inspected hierarchically.
//
// Optional feature macro: MIPS32_MEM_ERR_EN
//   defined   -> resp_err_o port exists and flags out-of-range accesses
//   undefined -> no resp_err_o port; out-of-range accesses are silent
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid_i   request present
//   req_ready_o   high only in IDLE while rst_n is high
//   req_we_i      1 = store, 0 = load
//   req_addr_i    word address
//   req_wdata_i   store data
//   resp_valid_o  response present (RESP state)
//   resp_ready_i  initiator accepts response
//   resp_rdata_o  load data; a store echoes its data word
//   busy_o        high in WAIT or RESP
//   resp_err_o    out-of-range flag, valid with resp_valid_o (macro only)
// -----------------------------------------------------------------------------
module mips32_data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              busy_o
`ifdef MIPS32_MEM_ERR_EN
  ,
  output logic              resp_err_o
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                capture_s;
  logic                commit_s;
  logic                in_range_s;
  logic [IDX_W-1:0]    idx_s;
  logic [DATA_W-1:0]   rd_word_s;

  logic [DATA_W-1:0]   MEM [DEPTH];

  // Range check on the captured address; the index is only trusted when in range.
  assign in_range_s = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
  assign idx_s      = addr_q[IDX_W-1:0];
  assign rd_word_s  = MEM[idx_s];

  // Next-state and handshake decode for the IDLE/WAIT/RESP controller.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    commit_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          capture_s = 1'b1;
          cnt_d     = 4'(WAIT_CYCLES);
          state_d   = S_WAIT;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_WAIT: begin
        // The access happens on the edge where the countdown is already zero.
        if (cnt_q != 4'd0) begin
          cnt_d    = cnt_q - 4'd1;
        end else begin
          commit_s = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Response word: stores echo their data, out-of-range loads return zero.
  always_comb begin
    rdata_d = '0;
    if (we_q) begin
      rdata_d = wdata_q;
    end else if (in_range_s) begin
      rdata_d = rd_word_s;
    end else begin
      rdata_d = '0;
    end
  end

  // Controller state, captured request and held response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture_s) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (commit_s) begin
        rdata_q <= rdata_d;
      end
    end
  end

  // Array write port: not reset, and written only on the commit edge of an
  // in-range store (commit_s is forced low while rst_n is asserted). A plain
  // always block keeps the array writable hierarchically for preloading.
  always @(posedge clk) begin
    if (commit_s && we_q && in_range_s) begin
      MEM[idx_s] <= wdata_q;
    end
  end

`ifdef MIPS32_MEM_ERR_EN
  logic err_q;

  // Out-of-range flag, latched with the response word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (commit_s) begin
      err_q <= ~in_range_s;
    end
  end

  assign resp_err_o = err_q && (state_q == S_RESP);
`endif

  // req_ready is gated by rst_n so it stays low for the whole reset interval.
  assign req_ready_o  = (state_q == S_IDLE) && rst_n;
  assign resp_valid_o = (state_q == S_RESP);
  assign busy_o       = (state_q == S_WAIT) || (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;

endmodule
